// File: rtl/vgg16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vgg16_pkg
// Description : Shared constants and types for the VGG16 layer pipeline:
//               default word/channel sizes, per-layer frame widths and the
//               feature-map replay buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vgg16_pkg;

  // Default pixel geometry: 32 channel words of 32 bits each
  localparam int c_data_width = 32;
  localparam int c_channels   = 32;

  // Frame side length entering each convolution block
  localparam int c_width_blk1 = 224;
  localparam int c_width_blk2 = 112;
  localparam int c_width_blk3 = 56;
  localparam int c_width_blk4 = 28;
  localparam int c_width_blk5 = 14;
  localparam int c_width_out  = 7;

  // Replay buffer states
  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    FULL    = 2'd1,
    STREAM  = 2'd2
  } fmap_state_t;

  // Address width for a memory of 'dim' entries (never less than one bit)
  function automatic int fmap_addr_bits(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_replay_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : fmap_replay_buf_if
// Description : Pixel-stream bundle between a layer producer, the replay
//               buffer and the next layer. 'master' drives pixels in and
//               requests replay; 'slave' is the buffer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fmap_replay_buf_if
  import vgg16_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int CHANNELS   = c_channels
);

  logic [DATA_WIDTH*CHANNELS-1:0] i_data;
  logic                           valid_in;
  logic                           start;
  logic [DATA_WIDTH*CHANNELS-1:0] o_data;
  logic                           valid_out;
  logic                           full;
  logic                           frame_done;
  logic                           overflow;

  modport master (
    output i_data, valid_in, start,
    input  o_data, valid_out, full, frame_done, overflow
  );

  modport slave (
    input  i_data, valid_in, start,
    output o_data, valid_out, full, frame_done, overflow
  );

endinterface
`default_nettype wire

// File: rtl/fmap_ram.sv
`default_nettype none
// ============================================================================
// Module      : fmap_ram
// Description : Simple dual-port synchronous RAM, one write and one read
//               port. Read data is registered (1-cycle latency), holds its
//               value when no read is issued and clears on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_ram #(
  parameter int WORD_BITS = 1024,
  parameter int DEPTH     = 784,
  parameter int ADDR_BITS = 10
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_we,
  input  wire logic [ADDR_BITS-1:0] i_waddr,
  input  wire logic [WORD_BITS-1:0] i_wdata,
  input  wire logic                 i_re,
  input  wire logic [ADDR_BITS-1:0] i_raddr,
  output logic      [WORD_BITS-1:0] o_rdata
);

  logic [WORD_BITS-1:0] r_mem [DEPTH];

  // Write port; contents are not reset, only the read register is
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port, holding the last word between reads
  always_ff @(posedge clk) begin
    if (rst)       o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/fmap_replay_buf.sv
`default_nettype none
// ============================================================================
// Module      : fmap_replay_buf
// Description : Full-frame feature-map buffer. Captures WIDTH*WIDTH pixels,
//               then replays them in raster order as a gapless stream.
//               Build option FMAP_REPLAY_AUTOSTART_EN: replay starts on its
//               own one cycle after the frame completes (start ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_replay_buf
  import vgg16_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int CHANNELS   = c_channels,
  parameter int WIDTH      = c_width_blk4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fmap_replay_buf_if.slave bus
);

  localparam int c_dim = WIDTH * WIDTH;
  localparam int c_pw  = DATA_WIDTH * CHANNELS;
  localparam int c_aw  = fmap_addr_bits(c_dim);
  localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_dim - 1);

  fmap_state_t     r_state;
  logic [c_aw-1:0] r_wr_addr;
  logic [c_aw-1:0] r_rd_addr;
  logic            r_full;
  logic            r_valid_out;
  logic            r_frame_done;
  logic            r_overflow;

  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_start_req;
  logic [c_pw-1:0] w_rd_data;

  // Writes only happen in CAPTURE and reads only in STREAM, so the two RAM
  // ports never touch the same address in the same cycle.
  assign w_wr_en = (r_state == CAPTURE) && bus.valid_in;
  assign w_rd_en = (r_state == STREAM);

`ifdef FMAP_REPLAY_AUTOSTART_EN
  assign w_start_req = 1'b1;
`else
  assign w_start_req = bus.start;
`endif

  // Frame sequencing: capture addressing, replay addressing and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CAPTURE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_full       <= 1'b0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // Read data appears one cycle after the read is issued
      r_valid_out  <= (r_state == STREAM);
      r_frame_done <= (r_state == STREAM) && (r_rd_addr == c_last_addr);
      if (bus.valid_in && (r_state != CAPTURE)) r_overflow <= 1'b1;

      case (r_state)
        CAPTURE: begin
          if (bus.valid_in) begin
            if (r_wr_addr == c_last_addr) begin
              r_wr_addr <= '0;
              r_full    <= 1'b1;
              r_state   <= FULL;
            end else begin
              r_wr_addr <= r_wr_addr + 1'b1;
            end
          end
        end
        FULL: begin
          if (w_start_req) begin
            r_rd_addr <= '0;
            r_full    <= 1'b0;
            r_state   <= STREAM;
          end
        end
        STREAM: begin
          if (r_rd_addr == c_last_addr) begin
            r_rd_addr <= '0;
            r_state   <= CAPTURE;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default: r_state <= CAPTURE;
      endcase
    end
  end

  fmap_ram #(
    .WORD_BITS (c_pw),
    .DEPTH     (c_dim),
    .ADDR_BITS (c_aw)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (bus.i_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign bus.o_data     = w_rd_data;
  assign bus.valid_out  = r_valid_out;
  assign bus.full       = r_full;
  assign bus.frame_done = r_frame_done;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire
